i2s_receiver: RTL and testbench

Deserializing I2S receiver: the receive end of the I2S link that `i2s_controller` drives. It oversamples the external `bit_clk`, `frame_clk` and `data` lines on the system clock and recovers each stereo frame as a pair of parallel samples with a one-cycle valid strobe. It is used for loopback checking of the synth's audio output and as the front end for an external ADC/codec input path.

---
 rtl/i2s_receiver.sv | 165 ++++++++++++++++
 tb/tb_i2s_receiver.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_receiver.sv
// i2s_receiver -- Philips I2S deserialiser.
//
// Oversamples the external bit_clk / frame_clk / data lines on the system
// clock and recovers each stereo frame as a parallel left/right sample pair.
// The sample outputs are loaded together with a one-cycle sample_valid pulse.
// The first partial frame after reset is always discarded: the FSM waits in
// SYNC for a right->left word-select boundary before it accepts any words.
//
// Optional feature: define I2S_RX_FRAME_ERR_EN to build the sticky word-length
// checker behind frame_err. Without it frame_err is tied low.
//
// Parameters:
//   SAMPLE_WIDTH   bits per channel word on the outputs (default 16)
// Ports:
//   clk            system clock, at least 4x the bit_clk frequency
//   reset          asynchronous active-low reset
//   bit_clk        serial bit clock (asynchronous to clk)
//   frame_clk      word select, 0 = left, 1 = right (asynchronous to clk)
//   data           serial data, MSB first
//   sample_left    last complete left word
//   sample_right   last complete right word
//   sample_valid   one-clk pulse when a new left/right pair is loaded
//   frame_err      sticky word-length error flag
module i2s_receiver #(
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    bit_clk,
  input  logic                    frame_clk,
  input  logic                    data,
  output logic [SAMPLE_WIDTH-1:0] sample_left,
  output logic [SAMPLE_WIDTH-1:0] sample_right,
  output logic                    sample_valid,
  output logic                    frame_err
);

  // Counter must hold SAMPLE_WIDTH+1, where it saturates.
  localparam int CW = $clog2(SAMPLE_WIDTH + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(SAMPLE_WIDTH + 1);

  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

  state_t state, state_nx;

  logic bclk_p0, bclk_p1, bclk_p2;
  logic ws_p0, ws_p1;
  logic dat_p0, dat_p1;

  logic                    ws_d;
  logic [CW-1:0]           cnt;
  logic [SAMPLE_WIDTH-1:0] word;
  logic [SAMPLE_WIDTH-1:0] word_bit;
  logic [SAMPLE_WIDTH-1:0] left_hold;

  logic rise;
  logic boundary;
  logic load_hold;
  logic emit;

  // Stage p0/p1: two-flop synchronisers; p2: bit_clk edge detector
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bclk_p0 <= 1'b0;
      bclk_p1 <= 1'b0;
      bclk_p2 <= 1'b0;
      ws_p0   <= 1'b0;
      ws_p1   <= 1'b0;
      dat_p0  <= 1'b0;
      dat_p1  <= 1'b0;
    end else begin
      bclk_p0 <= bit_clk;
      bclk_p1 <= bclk_p0;
      bclk_p2 <= bclk_p1;
      ws_p0   <= frame_clk;
      ws_p1   <= ws_p0;
      dat_p0  <= data;
      dat_p1  <= dat_p0;
    end
  end

  assign rise     = bclk_p1 & ~bclk_p2;
  assign boundary = rise & (ws_p1 != ws_d);

  // Current word with this rise's bit placed; bits past SAMPLE_WIDTH drop out
  // because no index matches once cnt >= SAMPLE_WIDTH.
  always_comb begin
    word_bit = word;
    for (int i = 0; i < SAMPLE_WIDTH; i++) begin
      if (cnt == CW'(SAMPLE_WIDTH - 1 - i)) word_bit[i] = dat_p1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SYNC;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    load_hold = 1'b0;
    emit      = 1'b0;
    if (boundary) begin
      case (state)
        SYNC:  if (!ws_p1) state_nx = LEFT;
        LEFT:  if (ws_p1) begin
                 load_hold = 1'b1;
                 state_nx  = RIGHT;
               end
        RIGHT: if (!ws_p1) begin
                 emit     = 1'b1;
                 state_nx = LEFT;
               end
        default: state_nx = SYNC;
      endcase
    end
  end

  // Word assembly and output registers, all advancing on rise only
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ws_d         <= 1'b0;
      cnt          <= '0;
      word         <= '0;
      left_hold    <= '0;
      sample_left  <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= emit;
      if (rise) begin
        ws_d <= ws_p1;
        if (boundary) begin
          word <= '0;
          cnt  <= '0;
        end else begin
          word <= word_bit;
          if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
        end
      end
      if (load_hold) left_hold <= word_bit;
      if (emit) begin
        sample_left  <= left_hold;
        sample_right <= word_bit;
      end
    end
  end

`ifdef I2S_RX_FRAME_ERR_EN
  // The boundary bit is the word's last, so a correct word has cnt at
  // SAMPLE_WIDTH-1 when the boundary arrives.
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_WIDTH - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err <= 1'b0;
    end else if (boundary && (state != SYNC) && (cnt != CNT_LAST)) begin
      frame_err <= 1'b1;
    end
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
module tb_i2s_receiver;

  localparam int SW = 16;
`ifdef I2S_RX_FRAME_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          bit_clk;
  logic          frame_clk;
  logic          data;
  logic [SW-1:0] sample_left;
  logic [SW-1:0] sample_right;
  logic          sample_valid;
  logic          frame_err;

  int      nvec = 0;
  int      nerr = 0;
  int      vcount = 0;
  logic [SW-1:0] cap_l = '0;
  logic [SW-1:0] cap_r = '0;
  logic [SW-1:0] prev_l = '0;
  logic [SW-1:0] prev_r = '0;
  logic    rst_q = 1'b0;
  time     valid_time = 0;
  time     last_rise = 0;
  time     first_rise = 0;
  time     lat;
  logic    pend = 1'b0;

  i2s_receiver #(.SAMPLE_WIDTH(SW)) dut (
    .clk          (clk),
    .reset        (reset),
    .bit_clk      (bit_clk),
    .frame_clk    (frame_clk),
    .data         (data),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
      else begin
        nerr++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // One bit period (clk/8): data and word select change while bit_clk is low.
  task automatic send_raw(input logic w, input logic b);
    bit_clk   = 1'b0;
    frame_clk = w;
    data      = b;
    #40;
    bit_clk   = 1'b1;
    last_rise = $time;
    #40;
  endtask

  // Sends n periods with word select w: previous word's LSB, then val[n-1:1].
  // val[0] is left pending for the first period of the next word.
  task automatic send_word(input logic w, input logic [31:0] val, input int n);
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        send_raw(w, pend);
        first_rise = last_rise;
      end else begin
        send_raw(w, val[n-i]);
      end
    end
    pend = val[0];
  endtask

  // Boundary bit back to left that closes the last right word.
  task automatic flush();
    send_raw(1'b0, pend);
    first_rise = last_rise;
    pend = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    bit_clk   = 1'b0;
    frame_clk = 1'b0;
    data      = 1'b0;
    pend      = 1'b0;
    #20;
    reset     = 1'b1;
  endtask

  // Pair capture plus check that outputs never move without sample_valid.
  initial begin
    forever begin
      @(negedge clk);
      if (sample_valid) begin
        vcount++;
        cap_l      = sample_left;
        cap_r      = sample_right;
        valid_time = $time - 5;
      end else if (reset && rst_q) begin
        nvec++;
        assert (sample_left === prev_l && sample_right === prev_r)
          else begin
            nerr++;
            $error("FAIL hold: observed %h/%h expected %h/%h",
                   sample_left, sample_right, prev_l, prev_r);
          end
      end
      prev_l = sample_left;
      prev_r = sample_right;
      rst_q  = reset;
    end
  end

  initial begin
    reset     = 1'b0;
    bit_clk   = 1'b0;
    frame_clk = 1'b0;
    data      = 1'b0;
    @(posedge clk);
    #2;

    // Reset held with lines toggling
    send_word(1'b0, 32'h0F0F, 8);
    send_word(1'b1, 32'hF0F0, 8);
    send_word(1'b0, 32'h1234, 16);
    chk("rst_left",  sample_left,  0);
    chk("rst_right", sample_right, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_err",   frame_err,    0);
    chk("rst_count", vcount,       0);
    reset = 1'b1;
    pend  = 1'b0;
    send_word(1'b1, 32'h5, 4);
    chk("post_rst_left", sample_left, 0);
    chk("post_rst_count", vcount, 0);

    // Two 16-bit frames
    do_reset();
    send_word(1'b0, 32'h0, 4);
    send_word(1'b1, 32'h0, 4);
    send_word(1'b0, 32'hA5C3, 16);
    send_word(1'b1, 32'h1234, 16);
    send_word(1'b0, 32'h8001, 16);
    chk("f1_count", vcount, 1);
    chk("f1_left",  cap_l, 32'hA5C3);
    chk("f1_right", cap_r, 32'h1234);
    lat = valid_time - first_rise;
    chk("f1_latency", (lat >= 20 && lat <= 30), 1);
    send_word(1'b1, 32'h7FFE, 16);
    flush();
    chk("f2_count", vcount, 2);
    chk("f2_left",  cap_l, 32'h8001);
    chk("f2_right", cap_r, 32'h7FFE);
    chk("f2_out_left", sample_left, 32'h8001);
    lat = valid_time - first_rise;
    chk("f2_latency", (lat >= 20 && lat <= 30), 1);
    chk("f2_err", frame_err, 0);

    // Start mid right word
    do_reset();
    send_word(1'b1, 32'h55, 7);
    send_word(1'b0, 32'h5A5A, 16);
    chk("mid_no_valid", vcount, 2);
    send_word(1'b1, 32'hC3C3, 16);
    flush();
    chk("mid_count", vcount, 3);
    chk("mid_left",  cap_l, 32'h5A5A);
    chk("mid_right", cap_r, 32'hC3C3);
    chk("mid_err",   frame_err, 0);

    // Short 12-bit words
    do_reset();
    send_word(1'b1, 32'h0, 3);
    send_word(1'b0, 32'hABC, 12);
    send_word(1'b1, 32'h123, 12);
    flush();
    chk("short_count", vcount, 4);
    chk("short_left",  cap_l, 32'hABC0);
    chk("short_right", cap_r, 32'h1230);
    chk("short_err",   frame_err, ERR_EN);

    // Long 20-bit words
    do_reset();
    chk("long_rst_err", frame_err, 0);
    send_word(1'b1, 32'h0, 3);
    send_word(1'b0, 32'hFEDCB, 20);
    send_word(1'b1, 32'h54321, 20);
    flush();
    chk("long_count", vcount, 5);
    chk("long_left",  cap_l, 32'hFEDC);
    chk("long_right", cap_r, 32'h5432);
    chk("long_err",   frame_err, ERR_EN);

    // Reset pulsed during a left word
    do_reset();
    send_word(1'b1, 32'h0, 3);
    send_word(1'b0, 32'h1357, 16);
    send_word(1'b1, 32'h2468, 16);
    send_raw(1'b0, pend);
    chk("pre_count", vcount, 6);
    chk("pre_left",  cap_l, 32'h1357);
    chk("pre_right", cap_r, 32'h2468);
    for (int i = 0; i < 5; i++) send_raw(1'b0, 1'b1);
    do_reset();
    #1;
    chk("mid_rst_left",  sample_left,  0);
    chk("mid_rst_right", sample_right, 0);
    chk("mid_rst_err",   frame_err,    0);
    #9;
    for (int i = 0; i < 10; i++) send_raw(1'b0, 1'b0);
    pend = 1'b1;
    send_word(1'b1, 32'h4444, 16);
    send_word(1'b0, 32'h0C0C, 16);
    send_word(1'b1, 32'hF00F, 16);
    chk("abort_no_valid", vcount, 6);
    flush();
    chk("rec_count", vcount, 7);
    chk("rec_left",  cap_l, 32'h0C0C);
    chk("rec_right", cap_r, 32'hF00F);
    chk("rec_err",   frame_err, 0);

    #40;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
